axi_lite_regfile: RTL and testbench

AXI_LITE_REGFILE -- requirements
Module: axi_lite_regfile

---
 rtl/axi_lite_pkg.sv | 20 ++
 rtl/axi_lite_inf.sv | 35 +++
 rtl/axi_lite_wr_hold.sv | 42 ++++
 rtl/axi_lite_regfile.sv | 153 +++++++++++++++
 tb/tb_axi_lite_regfile.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_pkg.sv
// Shared response codes and FSM state types for the AXI-Lite register file.
// Pure definitions: no logic, no latency, no backpressure.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WIDLE   = 2'd0,
    WHAVE_A = 2'd1,
    WHAVE_D = 2'd2,
    WRESP   = 2'd3
  } wr_state_t;

  typedef enum logic {
    RIDLE = 1'b0,
    RDATA = 1'b1
  } rd_state_t;

endpackage

// File: rtl/axi_lite_inf.sv
// AXI-Lite bus bundle: AW/W/B write channels plus AR/R read channels.
// Wiring only; valid/ready backpressure is carried on every channel.
interface axi_lite_inf #(
  parameter int ASIZE = 32,
  parameter int DSIZE = 32
);

  logic             awvalid;
  logic             awready;
  logic [ASIZE-1:0] awaddr;
  logic             wvalid;
  logic             wready;
  logic [DSIZE-1:0] wdata;
  logic             bvalid;
  logic             bready;
  logic [1:0]       bresp;
  logic             arvalid;
  logic             arready;
  logic [ASIZE-1:0] araddr;
  logic             rvalid;
  logic             rready;
  logic [DSIZE-1:0] rdata;
  logic [1:0]       rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/axi_lite_wr_hold.sv
// Holds whichever of AW/W arrives first and presents the effective address/data, register index and range flag.
// Zero latency: a handshake in the current cycle bypasses the holding register; no backpressure of its own.
module axi_lite_wr_hold #(
  parameter int ASIZE = 32,
  parameter int DSIZE = 32,
  parameter int NREG  = 8,
  localparam int IDXW = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             aw_fire,
  input  logic [ASIZE-1:0] awaddr,
  input  logic             w_fire,
  input  logic [DSIZE-1:0] wdata,
  output logic [IDXW-1:0]  wr_idx,
  output logic             wr_in_range,
  output logic [DSIZE-1:0] wr_data
);

  logic [ASIZE-1:0] addr_q;
  logic [DSIZE-1:0] data_q;
  logic [ASIZE-1:0] eff_addr;
  logic             unused_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      data_q <= '0;
    end else begin
      if (aw_fire) addr_q <= awaddr;
      if (w_fire)  data_q <= wdata;
    end
  end

  // The later handshake commits on its own edge, so its bus value must bypass the hold register.
  assign eff_addr    = aw_fire ? awaddr : addr_q;
  assign wr_data     = w_fire ? wdata : data_q;
  assign wr_idx      = eff_addr[IDXW+1:2];
  assign wr_in_range = ((eff_addr >> (IDXW + 2)) == '0);
  assign unused_lo   = ^eff_addr[1:0];

endmodule

// File: rtl/axi_lite_regfile.sv
// AXI-Lite slave register file: NREG x DSIZE registers, independent write and read FSMs.
// Write response 1 cycle after the later AW/W handshake, read data 1 cycle after AR; responses hold until bready/rready.
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int ASIZE = 32,
  parameter int DSIZE = 32,
  parameter int NREG  = 8
) (
  input  logic                  axi_lite_aclk,
  input  logic                  axi_lite_reset,
  axi_lite_inf.slave            axi,
  output logic [NREG*DSIZE-1:0] reg_q,
  output logic [NREG-1:0]       reg_wr_pulse
);

  localparam int IDXW = $clog2(NREG);

  wr_state_t        wr_state, wr_state_nxt;
  rd_state_t        rd_state, rd_state_nxt;
  logic             aw_fire, w_fire, ar_fire;
  logic             wr_commit;
  logic [IDXW-1:0]  wr_idx;
  logic             wr_in_range;
  logic [DSIZE-1:0] wr_data;
  logic [IDXW-1:0]  ar_idx;
  logic             ar_in_range;
  logic             unused_ar_lo;
  logic [1:0]       bresp_q;
  logic [DSIZE-1:0] rdata_q;
  logic [1:0]       rresp_q;
  logic [DSIZE-1:0] regs [NREG];

  // ---------------- write path ----------------
  assign axi.awready = (wr_state == WIDLE) || (wr_state == WHAVE_D);
  assign axi.wready  = (wr_state == WIDLE) || (wr_state == WHAVE_A);
  assign aw_fire     = axi.awvalid && axi.awready;
  assign w_fire      = axi.wvalid && axi.wready;
  assign axi.bvalid  = (wr_state == WRESP);
  assign axi.bresp   = bresp_q;

  axi_lite_wr_hold #(
    .ASIZE (ASIZE),
    .DSIZE (DSIZE),
    .NREG  (NREG)
  ) u_wr_hold (
    .clk         (axi_lite_aclk),
    .rst         (axi_lite_reset),
    .aw_fire     (aw_fire),
    .awaddr      (axi.awaddr),
    .w_fire      (w_fire),
    .wdata       (axi.wdata),
    .wr_idx      (wr_idx),
    .wr_in_range (wr_in_range),
    .wr_data     (wr_data)
  );

  always_ff @(posedge axi_lite_aclk or posedge axi_lite_reset) begin
    if (axi_lite_reset) wr_state <= WIDLE;
    else                wr_state <= wr_state_nxt;
  end

  always_comb begin
    wr_state_nxt = wr_state;
    wr_commit    = 1'b0;
    case (wr_state)
      WIDLE: begin
        if (aw_fire && w_fire) begin
          wr_state_nxt = WRESP;
          wr_commit    = 1'b1;
        end else if (aw_fire) begin
          wr_state_nxt = WHAVE_A;
        end else if (w_fire) begin
          wr_state_nxt = WHAVE_D;
        end
      end
      WHAVE_A: begin
        if (w_fire) begin
          wr_state_nxt = WRESP;
          wr_commit    = 1'b1;
        end
      end
      WHAVE_D: begin
        if (aw_fire) begin
          wr_state_nxt = WRESP;
          wr_commit    = 1'b1;
        end
      end
      WRESP: begin
        if (axi.bready) wr_state_nxt = WIDLE;
      end
      default: wr_state_nxt = WIDLE;
    endcase
  end

  always_ff @(posedge axi_lite_aclk or posedge axi_lite_reset) begin
    if (axi_lite_reset) begin
      bresp_q      <= RESP_OKAY;
      reg_wr_pulse <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      reg_wr_pulse <= '0;
      if (wr_commit) begin
        bresp_q <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
        if (wr_in_range) begin
          regs[wr_idx]         <= wr_data;
          reg_wr_pulse[wr_idx] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NREG; i++) reg_q[i*DSIZE +: DSIZE] = regs[i];
  end

  // ---------------- read path ----------------
  assign axi.arready  = (rd_state == RIDLE);
  assign ar_fire      = axi.arvalid && axi.arready;
  assign ar_idx       = axi.araddr[IDXW+1:2];
  assign ar_in_range  = ((axi.araddr >> (IDXW + 2)) == '0);
  assign unused_ar_lo = ^axi.araddr[1:0];
  assign axi.rvalid   = (rd_state == RDATA);
  assign axi.rdata    = rdata_q;
  assign axi.rresp    = rresp_q;

  always_ff @(posedge axi_lite_aclk or posedge axi_lite_reset) begin
    if (axi_lite_reset) rd_state <= RIDLE;
    else                rd_state <= rd_state_nxt;
  end

  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      RIDLE:   if (ar_fire) rd_state_nxt = RDATA;
      RDATA:   if (axi.rready) rd_state_nxt = RIDLE;
      default: rd_state_nxt = RIDLE;
    endcase
  end

  // Sampling regs here with non-blocking semantics returns the pre-write value on a same-edge update.
  always_ff @(posedge axi_lite_aclk or posedge axi_lite_reset) begin
    if (axi_lite_reset) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_fire) begin
      rdata_q <= ar_in_range ? regs[ar_idx] : '0;
      rresp_q <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Bench for axi_lite_regfile: vector table, directed corner sequences, then random traffic against an array model.
module tb_axi_lite_regfile;

  localparam int NREG = 8;
  localparam int DSIZE = 32;

  logic clk;
  logic rst;
  logic [NREG*DSIZE-1:0] reg_q;
  logic [NREG-1:0]       reg_wr_pulse;

  int n_err;
  int n_checks;

  logic [31:0] model [NREG];

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
  } vec_t;

  vec_t vecs [11];

  axi_lite_inf #(.ASIZE(32), .DSIZE(32)) axi ();

  axi_lite_regfile #(.ASIZE(32), .DSIZE(32), .NREG(NREG)) dut (
    .axi_lite_aclk  (clk),
    .axi_lite_reset (rst),
    .axi            (axi.slave),
    .reg_q          (reg_q),
    .reg_wr_pulse   (reg_wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] pack_model();
    logic [255:0] p;
    p = '0;
    for (int i = 0; i < NREG; i++) p[i*32 +: 32] = model[i];
    return p;
  endfunction

  function automatic bit addr_ok(input logic [31:0] a);
    return a < 32'(NREG * 4);
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output logic [1:0] resp);
    int ad, wd, n;
    bit aw_done, w_done, a_hs, w_hs;
    ad = aw_dly; wd = w_dly; n = 0;
    aw_done = 0; w_done = 0;
    axi.awaddr = addr; axi.wdata = data; axi.bready = 0;
    while (!(aw_done && w_done) && n < 50) begin
      axi.awvalid = !aw_done && (ad == 0);
      axi.wvalid  = !w_done && (wd == 0);
      #0;
      a_hs = axi.awvalid && axi.awready;
      w_hs = axi.wvalid && axi.wready;
      @(posedge clk); #1;
      if (a_hs) aw_done = 1;
      if (w_hs) w_done = 1;
      if (ad > 0) ad--;
      if (wd > 0) wd--;
      n++;
    end
    axi.awvalid = 0; axi.wvalid = 0;
    check("wr_handshake_done", {255'd0, aw_done && w_done}, 256'd1);
    check("wr_latency_bvalid", {255'd0, axi.bvalid}, 256'd1);
    resp = axi.bresp;
    repeat (b_dly) begin
      @(posedge clk); #1;
      check("bvalid_hold", {255'd0, axi.bvalid}, 256'd1);
      check("bresp_hold", {254'd0, axi.bresp}, {254'd0, resp});
      check("awready_in_wresp", {255'd0, axi.awready}, 256'd0);
      check("wready_in_wresp", {255'd0, axi.wready}, 256'd0);
    end
    axi.bready = 1;
    @(posedge clk); #1;
    axi.bready = 0;
    check("bvalid_cleared", {255'd0, axi.bvalid}, 256'd0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp);
    int n;
    n = 0;
    axi.araddr = addr; axi.arvalid = 1; axi.rready = 0;
    #0;
    while (!axi.arready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    axi.arvalid = 0;
    check("rd_latency_rvalid", {255'd0, axi.rvalid}, 256'd1);
    check("arready_in_rdata", {255'd0, axi.arready}, 256'd0);
    data = axi.rdata; resp = axi.rresp;
    repeat (r_dly) begin
      @(posedge clk); #1;
      check("rvalid_hold", {255'd0, axi.rvalid}, 256'd1);
      check("rdata_hold", {224'd0, axi.rdata}, {224'd0, data});
    end
    axi.rready = 1;
    @(posedge clk); #1;
    axi.rready = 0;
    check("rvalid_cleared", {255'd0, axi.rvalid}, 256'd0);
  endtask

  initial begin
    logic [1:0]   resp;
    logic [31:0]  rd;
    logic [255:0] snap;
    logic [31:0]  a, d, val_a, val_b;

    n_err = 0; n_checks = 0;
    axi.awvalid = 0; axi.awaddr = '0; axi.wvalid = 0; axi.wdata = '0; axi.bready = 0;
    axi.arvalid = 0; axi.araddr = '0; axi.rready = 0;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bvalid", {255'd0, axi.bvalid}, 256'd0);
    check("rst_rvalid", {255'd0, axi.rvalid}, 256'd0);
    check("rst_rdata", {224'd0, axi.rdata}, 256'd0);
    check("rst_regs", reg_q, 256'd0);
    check("rst_pulse", {248'd0, reg_wr_pulse}, 256'd0);
    @(negedge clk); rst = 0;
    #1;
    check("rel_awready", {255'd0, axi.awready}, 256'd1);
    check("rel_wready", {255'd0, axi.wready}, 256'd1);
    check("rel_arready", {255'd0, axi.arready}, 256'd1);
    @(posedge clk); #1;

    // ---------------- table-driven vectors ----------------
    vecs[0]  = '{1'b1, 32'h0000_0000, 32'h1111_1111, 2'b00};
    vecs[1]  = '{1'b1, 32'h0000_0008, 32'h2222_2222, 2'b00};
    vecs[2]  = '{1'b1, 32'h0000_0020, 32'h3333_3333, 2'b10};
    vecs[3]  = '{1'b0, 32'h0000_0000, 32'h1111_1111, 2'b00};
    vecs[4]  = '{1'b0, 32'h0000_0008, 32'h2222_2222, 2'b00};
    vecs[5]  = '{1'b0, 32'h0000_0020, 32'h0000_0000, 2'b10};
    vecs[6]  = '{1'b1, 32'h0000_001F, 32'h7777_7777, 2'b00};
    vecs[7]  = '{1'b0, 32'h0000_001C, 32'h7777_7777, 2'b00};
    vecs[8]  = '{1'b1, 32'hFFFF_0000, 32'h9999_9999, 2'b10};
    vecs[9]  = '{1'b0, 32'h8000_0004, 32'h0000_0000, 2'b10};
    vecs[10] = '{1'b0, 32'h0000_0005, 32'h0000_0000, 2'b00};

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].is_wr) begin
        snap = reg_q;
        axi_write(vecs[i].addr, vecs[i].data, 0, 0, 0, resp);
        check($sformatf("vec%0d_bresp", i), {254'd0, resp}, {254'd0, vecs[i].resp});
        if (vecs[i].resp != 2'b00)
          check($sformatf("vec%0d_regs_unchanged", i), reg_q, snap);
        else
          check($sformatf("vec%0d_reg", i), {224'd0, reg_q[vecs[i].addr[4:2]*32 +: 32]},
                {224'd0, vecs[i].data});
      end else begin
        axi_read(vecs[i].addr, 0, rd, resp);
        check($sformatf("vec%0d_rdata", i), {224'd0, rd}, {224'd0, vecs[i].data});
        check($sformatf("vec%0d_rresp", i), {254'd0, resp}, {254'd0, vecs[i].resp});
      end
    end

    // ---------------- AW and W in the same cycle ----------------
    axi.awvalid = 1; axi.awaddr = 32'h4; axi.wvalid = 1; axi.wdata = 32'hDEAD_BEEF; axi.bready = 1;
    @(posedge clk); #1;
    axi.awvalid = 0; axi.wvalid = 0;
    check("same_cyc_bvalid", {255'd0, axi.bvalid}, 256'd1);
    check("same_cyc_bresp", {254'd0, axi.bresp}, 256'd0);
    check("same_cyc_reg1", {224'd0, reg_q[32 +: 32]}, {224'd0, 32'hDEAD_BEEF});
    check("same_cyc_pulse", {248'd0, reg_wr_pulse}, {248'd0, 8'h02});
    @(posedge clk); #1;
    axi.bready = 0;
    check("same_cyc_pulse_gone", {248'd0, reg_wr_pulse}, 256'd0);
    check("same_cyc_bvalid_gone", {255'd0, axi.bvalid}, 256'd0);

    // ---------------- W leads AW by 3 cycles ----------------
    axi.wvalid = 1; axi.wdata = 32'h1234_5678; axi.bready = 1;
    @(posedge clk); #1;
    axi.wvalid = 0;
    for (int i = 0; i < 3; i++) begin
      check("have_d_awready", {255'd0, axi.awready}, 256'd1);
      check("have_d_wready", {255'd0, axi.wready}, 256'd0);
      check("have_d_no_bvalid", {255'd0, axi.bvalid}, 256'd0);
      if (i < 2) begin @(posedge clk); #1; end
    end
    axi.awvalid = 1; axi.awaddr = 32'h1C;
    @(posedge clk); #1;
    axi.awvalid = 0;
    check("have_d_bvalid", {255'd0, axi.bvalid}, 256'd1);
    check("have_d_reg7", {224'd0, reg_q[7*32 +: 32]}, {224'd0, 32'h1234_5678});
    check("have_d_pulse", {248'd0, reg_wr_pulse}, {248'd0, 8'h80});
    @(posedge clk); #1;
    axi.bready = 0;

    // ---------------- bready stalled 5 cycles, then same-edge write/read ----------------
    val_a = 32'hA5A5_0002; val_b = 32'h5A5A_0202;
    axi_write(32'h8, val_a, 0, 0, 5, resp);
    check("stall_bresp", {254'd0, resp}, 256'd0);
    axi.awvalid = 1; axi.awaddr = 32'h8; axi.wvalid = 1; axi.wdata = val_b; axi.bready = 0;
    axi.arvalid = 1; axi.araddr = 32'h8; axi.rready = 0;
    @(posedge clk); #1;
    axi.awvalid = 0; axi.wvalid = 0; axi.arvalid = 0;
    check("rw_same_edge_rvalid", {255'd0, axi.rvalid}, 256'd1);
    check("rw_same_edge_old", {224'd0, axi.rdata}, {224'd0, val_a});
    check("rw_same_edge_new_reg", {224'd0, reg_q[2*32 +: 32]}, {224'd0, val_b});
    axi.rready = 1; axi.bready = 1;
    @(posedge clk); #1;
    axi.rready = 0; axi.bready = 0;

    // ---------------- reset during RDATA ----------------
    axi.arvalid = 1; axi.araddr = 32'h8;
    @(posedge clk); #1;
    axi.arvalid = 0;
    check("pre_rst_rvalid", {255'd0, axi.rvalid}, 256'd1);
    @(posedge clk); #2;
    rst = 1;
    #1;
    check("mid_rst_rvalid", {255'd0, axi.rvalid}, 256'd0);
    check("mid_rst_regs", reg_q, 256'd0);
    check("mid_rst_rdata", {224'd0, axi.rdata}, 256'd0);
    @(negedge clk); rst = 0;
    #1;
    check("post_rst_arready", {255'd0, axi.arready}, 256'd1);
    check("post_rst_awready", {255'd0, axi.awready}, 256'd1);
    check("post_rst_wready", {255'd0, axi.wready}, 256'd1);
    @(posedge clk); #1;
    check("post_rst_arready_edge", {255'd0, axi.arready}, 256'd1);
    check("post_rst_rvalid", {255'd0, axi.rvalid}, 256'd0);

    // ---------------- random traffic vs array model ----------------
    for (int i = 0; i < NREG; i++) model[i] = '0;
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(32, 255));
      else                           a = 32'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        axi_write(a, d, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), resp);
        check("rnd_bresp", {254'd0, resp}, addr_ok(a) ? 256'd0 : 256'd2);
        if (addr_ok(a)) model[a / 4] = d;
        check("rnd_regs", reg_q, pack_model());
      end else begin
        axi_read(a, $urandom_range(0, 2), rd, resp);
        check("rnd_rdata", {224'd0, rd}, addr_ok(a) ? {224'd0, model[a / 4]} : 256'd0);
        check("rnd_rresp", {254'd0, resp}, addr_ok(a) ? 256'd0 : 256'd2);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
